// File: rtl/register_bank_param.sv
// register_bank_param: parametrised multi-read, dual-write register bank.
// Read data is registered, and a read of an address written in the same
// cycle returns the new write data.
// When both write ports hit the same address, port 1 wins.
// Optional build macro REG_BANK_ZERO_REG_EN makes register 0 read as zero.
// With the macro defined, writes to register 0 are also ignored.
module register_bank_param #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD-1:0]          read_en,
  input  logic [NUM_RD*ADDR_W-1:0]   read_addr,
  output logic [NUM_RD*DATA_W-1:0]   read_data,
  input  logic                       write0_en,
  input  logic [ADDR_W-1:0]          write0_addr,
  input  logic [DATA_W-1:0]          write0_val,
  input  logic                       write1_en,
  input  logic [ADDR_W-1:0]          write1_addr,
  input  logic [DATA_W-1:0]          write1_val,
  output logic                       collision
);

  logic [DATA_W-1:0]         r_mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0]  r_read_data;
  logic                      r_collision;

  logic                      w_en0_ok;
  logic                      w_en1_ok;
  logic                      w_same_addr;
  logic                      w_collision;
  logic                      w_we0;
  logic                      w_we1;
  logic [ADDR_W-1:0]         w_raddr [NUM_RD];
  logic [DATA_W-1:0]         w_fwd   [NUM_RD];

  // Qualify write enables, resolve same-address priority (port 1 wins).
  always_comb begin
    w_en0_ok    = write0_en;
    w_en1_ok    = write1_en;
`ifdef REG_BANK_ZERO_REG_EN
    w_en0_ok    = write0_en && (write0_addr != '0);
    w_en1_ok    = write1_en && (write1_addr != '0);
`endif
    w_same_addr = (write0_addr == write1_addr);
    w_collision = w_en0_ok && w_en1_ok && w_same_addr;
    w_we1       = w_en1_ok;
    w_we0       = w_en0_ok && !w_collision;
  end

  // Unpack read addresses per lane.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      w_raddr[i] = read_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Per-lane read value with same-cycle write forwarding.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      w_fwd[i] = r_mem[w_raddr[i]];
      if (w_we0 && (write0_addr == w_raddr[i])) begin
        w_fwd[i] = write0_val;
      end
      if (w_we1 && (write1_addr == w_raddr[i])) begin
        w_fwd[i] = write1_val;
      end
`ifdef REG_BANK_ZERO_REG_EN
      if (w_raddr[i] == '0) begin
        w_fwd[i] = '0;
      end
`endif
    end
  end

  // Register storage: async clear, up to two writes per edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_we0) begin
        r_mem[write0_addr] <= write0_val;
      end
      if (w_we1) begin
        r_mem[write1_addr] <= write1_val;
      end
    end
  end

  // Registered read lanes; disabled lanes hold their value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_data <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        if (read_en[i]) begin
          r_read_data[i*DATA_W +: DATA_W] <= w_fwd[i];
        end
      end
    end
  end

  // One-cycle collision flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_collision;
    end
  end

  assign read_data = r_read_data;
  assign collision = r_collision;

endmodule

// File: tb/tb_register_bank_param.sv
// Directed testbench for register_bank_param: default instance
// (16-bit, 32 deep, 2 read ports) plus a 32-bit, 8 deep, 4 read-port instance.
module tb_register_bank_param;

  logic        clk;
  logic        reset;

  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        w0_en, w1_en;
  logic [4:0]  w0_addr, w1_addr;
  logic [15:0] w0_val, w1_val;
  logic        coll;

  logic [3:0]   q_rd_en;
  logic [11:0]  q_rd_addr;
  logic [127:0] q_rd_data;
  logic         q_w0_en, q_w1_en;
  logic [2:0]   q_w0_addr, q_w1_addr;
  logic [31:0]  q_w0_val, q_w1_val;
  logic         q_coll;

  int checks;
  int failures;

  logic [15:0] exp_zero;

  register_bank_param u_dut (
    .clk(clk), .reset(reset),
    .read_en(rd_en), .read_addr(rd_addr), .read_data(rd_data),
    .write0_en(w0_en), .write0_addr(w0_addr), .write0_val(w0_val),
    .write1_en(w1_en), .write1_addr(w1_addr), .write1_val(w1_val),
    .collision(coll)
  );

  register_bank_param #(.DATA_W(32), .DEPTH(8), .NUM_RD(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .read_en(q_rd_en), .read_addr(q_rd_addr), .read_data(q_rd_data),
    .write0_en(q_w0_en), .write0_addr(q_w0_addr), .write0_val(q_w0_val),
    .write1_en(q_w1_en), .write1_addr(q_w1_addr), .write1_val(q_w1_val),
    .collision(q_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rd_en = '0; rd_addr = '0;
    w0_en = 0; w0_addr = '0; w0_val = '0;
    w1_en = 0; w1_addr = '0; w1_val = '0;
    q_rd_en = '0; q_rd_addr = '0;
    q_w0_en = 0; q_w0_addr = '0; q_w0_val = '0;
    q_w1_en = 0; q_w1_addr = '0; q_w1_val = '0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data, 32'h0); end
    checks++; if (coll !== 1'b0) begin failures++; $display("FAIL reset_coll got=%b exp=0", coll); end
    checks++; if (q_rd_data !== 128'h0) begin failures++; $display("FAIL reset_q_rd_data got=%h exp=0", q_rd_data); end
    reset = 1'b1;
    // Load reg 15 with 00AA via a colliding write (port 1 wins).
    w0_en = 1; w0_addr = 5'd15; w0_val = 16'h1111;
    w1_en = 1; w1_addr = 5'd15; w1_val = 16'h00AA;
    cyc();
    idle();
    // Read reg 15 and collide on reg 16 so both outputs are nonzero before the pulse.
    rd_en = 2'b01; rd_addr = {5'd0, 5'd15};
    w0_en = 1; w0_addr = 5'd16; w0_val = 16'h0001;
    w1_en = 1; w1_addr = 5'd16; w1_val = 16'h0002;
    cyc();
    idle();
    checks++; if (rd_data[15:0] !== 16'h00AA) begin failures++; $display("FAIL pre_reset_lane0 got=%h exp=%h", rd_data[15:0], 16'h00AA); end
    checks++; if (coll !== 1'b1) begin failures++; $display("FAIL pre_reset_coll got=%b exp=1", coll); end
    // Mid-cycle reset pulse: clears without a clock edge.
    #1 reset = 1'b0;
    #1;
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL async_reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (coll !== 1'b0) begin failures++; $display("FAIL async_reset_coll got=%b exp=0", coll); end
    #1 reset = 1'b1;
    rd_en = 2'b11; rd_addr = {5'd16, 5'd15};
    cyc();
    idle();
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL post_reset_read got=%h exp=0", rd_data); end
  endtask

  task automatic test_basic();
    idle();
    w0_en = 1; w0_addr = 5'd15; w0_val = 16'd20;
    w1_en = 1; w1_addr = 5'd16; w1_val = 16'h1234;
    cyc();
    checks++; if (coll !== 1'b0) begin failures++; $display("FAIL basic_no_coll got=%b exp=0", coll); end
    idle();
    rd_en = 2'b11; rd_addr = {5'd16, 5'd15};
    cyc();
    checks++; if (rd_data !== {16'h1234, 16'd20}) begin failures++; $display("FAIL basic_read got=%h exp=%h", rd_data, {16'h1234, 16'd20}); end
    idle();
    rd_en = 2'b01; rd_addr = {5'd15, 5'd16};
    cyc();
    checks++; if (rd_data !== {16'h1234, 16'h1234}) begin failures++; $display("FAIL basic_hold got=%h exp=%h", rd_data, {16'h1234, 16'h1234}); end
  endtask

  task automatic test_forward();
    idle();
    w1_en = 1; w1_addr = 5'd4; w1_val = 16'd10;
    rd_en = 2'b11; rd_addr = {5'd4, 5'd15};
    cyc();
    checks++; if (rd_data !== {16'd10, 16'd20}) begin failures++; $display("FAIL fwd_port1 got=%h exp=%h", rd_data, {16'd10, 16'd20}); end
    idle();
    w0_en = 1; w0_addr = 5'd5; w0_val = 16'h0055;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    cyc();
    checks++; if (rd_data[15:0] !== 16'h0055) begin failures++; $display("FAIL fwd_port0 got=%h exp=%h", rd_data[15:0], 16'h0055); end
    idle();
    rd_en = 2'b11; rd_addr = {5'd5, 5'd4};
    cyc();
    checks++; if (rd_data !== {16'h0055, 16'd10}) begin failures++; $display("FAIL fwd_stored got=%h exp=%h", rd_data, {16'h0055, 16'd10}); end
  endtask

  task automatic test_collision();
    idle();
    w0_en = 1; w0_addr = 5'd7; w0_val = 16'd5;
    w1_en = 1; w1_addr = 5'd7; w1_val = 16'd9;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    cyc();
    checks++; if (coll !== 1'b1) begin failures++; $display("FAIL coll_set got=%b exp=1", coll); end
    checks++; if (rd_data[15:0] !== 16'd9) begin failures++; $display("FAIL coll_fwd got=%h exp=%h", rd_data[15:0], 16'd9); end
    idle();
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
    cyc();
    checks++; if (coll !== 1'b0) begin failures++; $display("FAIL coll_clear got=%b exp=0", coll); end
    checks++; if (rd_data[31:16] !== 16'd9) begin failures++; $display("FAIL coll_stored got=%h exp=%h", rd_data[31:16], 16'd9); end
    idle();
    w0_en = 1; w0_addr = 5'd8; w0_val = 16'd1;
    w1_en = 1; w1_addr = 5'd9; w1_val = 16'd2;
    cyc();
    checks++; if (coll !== 1'b0) begin failures++; $display("FAIL coll_diff_addr got=%b exp=0", coll); end
    idle();
    rd_en = 2'b11; rd_addr = {5'd9, 5'd8};
    cyc();
    checks++; if (rd_data !== {16'd2, 16'd1}) begin failures++; $display("FAIL dual_write got=%h exp=%h", rd_data, {16'd2, 16'd1}); end
  endtask

  task automatic test_multiport();
    idle();
    q_w0_en = 1; q_w0_addr = 3'd3; q_w0_val = 32'hDEADBEEF;
    cyc();
    idle();
    q_rd_en = 4'hF; q_rd_addr = {3'd3, 3'd3, 3'd3, 3'd3};
    cyc();
    checks++; if (q_rd_data !== {4{32'hDEADBEEF}}) begin failures++; $display("FAIL multi_same got=%h exp=%h", q_rd_data, {4{32'hDEADBEEF}}); end
    idle();
    q_w0_en = 1; q_w0_addr = 3'd5; q_w0_val = 32'hA5A5A5A5;
    q_w1_en = 1; q_w1_addr = 3'd6; q_w1_val = 32'h5A5A5A5A;
    q_rd_en = 4'hF; q_rd_addr = {3'd0, 3'd6, 3'd5, 3'd3};
    cyc();
    checks++; if (q_rd_data !== {32'h0, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'hDEADBEEF})
      begin failures++; $display("FAIL multi_mixed got=%h exp=%h", q_rd_data, {32'h0, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'hDEADBEEF}); end
    checks++; if (q_coll !== 1'b0) begin failures++; $display("FAIL multi_coll got=%b exp=0", q_coll); end
  endtask

  task automatic test_zero_reg();
`ifdef REG_BANK_ZERO_REG_EN
    exp_zero = 16'h0000;
`else
    exp_zero = 16'hFFFF;
`endif
    idle();
    w0_en = 1; w0_addr = 5'd0; w0_val = 16'hFFFF;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
    cyc();
    checks++; if (rd_data[15:0] !== exp_zero) begin failures++; $display("FAIL zero_fwd got=%h exp=%h", rd_data[15:0], exp_zero); end
    idle();
    rd_en = 2'b10; rd_addr = {5'd0, 5'd0};
    cyc();
    checks++; if (rd_data[31:16] !== exp_zero) begin failures++; $display("FAIL zero_stored got=%h exp=%h", rd_data[31:16], exp_zero); end
    idle();
    w0_en = 1; w0_addr = 5'd0; w0_val = 16'h0001;
    w1_en = 1; w1_addr = 5'd0; w1_val = 16'h0002;
    cyc();
`ifdef REG_BANK_ZERO_REG_EN
    checks++; if (coll !== 1'b0) begin failures++; $display("FAIL zero_coll got=%b exp=0", coll); end
`else
    checks++; if (coll !== 1'b1) begin failures++; $display("FAIL zero_coll got=%b exp=1", coll); end
`endif
  endtask

  task automatic test_back_to_back();
    idle();
    w0_en = 1; w0_addr = 5'd20; w0_val = 16'h0101;
    rd_en = 2'b11; rd_addr = {5'd20, 5'd20};
    cyc();
    checks++; if (rd_data !== {16'h0101, 16'h0101}) begin failures++; $display("FAIL b2b_first got=%h exp=%h", rd_data, {16'h0101, 16'h0101}); end
    w0_en = 0;
    w1_en = 1; w1_addr = 5'd20; w1_val = 16'h0202;
    cyc();
    checks++; if (rd_data !== {16'h0202, 16'h0202}) begin failures++; $display("FAIL b2b_second got=%h exp=%h", rd_data, {16'h0202, 16'h0202}); end
    w1_en = 0;
    cyc();
    checks++; if (rd_data !== {16'h0202, 16'h0202}) begin failures++; $display("FAIL b2b_stored got=%h exp=%h", rd_data, {16'h0202, 16'h0202}); end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_forward();
    test_collision();
    test_multiport();
    test_zero_reg();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
